// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch queue.
//   - fetch_state_e : fetch FSM states (IDLE / REQ / DISCARD)
//   - INSTR_W       : instruction word width
//   - OPCODE/FONTEA/DEST field positions, and instr_fields_t, a packed view
//     of an instruction word for the decode stage
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int INSTR_W    = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;
  localparam int FONTEA_MSB = 28;
  localparam int FONTEA_LSB = 27;
  localparam int DEST_MSB   = 26;
  localparam int DEST_LSB   = 25;

  typedef struct packed {
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic [FONTEA_MSB-FONTEA_LSB:0] fonte_a;
    logic [DEST_MSB-DEST_LSB:0]     dest;
    logic [DEST_LSB-1:0]            rest;
  } instr_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no request outstanding
    ST_REQ     = 2'd1,  // request outstanding, data will be enqueued
    ST_DISCARD = 2'd2   // request outstanding, data will be dropped
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH x W synchronous FIFO with wrap-around pointers and a flush.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push         : write push_data (ignored when full unless popping too)
//   push_data    : entry to write
//   pop          : advance head (ignored when empty)
//   flush        : discard all entries (wins over push/pop)
//   head         : current head entry, all zeros when empty
//   count        : occupancy 0..DEPTH
//   empty, full  : occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // NOTE: storage has no reset; validity is tracked by the pointers/count,
  // which keeps the array a plain register file without a reset tree.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);  // DEPTH is a power of two: wraps
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage: owns the PC, requests words from instruction memory over a
// req/ack handshake, and queues {instruction, PC} pairs for the core.
// Ports:
//   Clk, Rst_n          : clock, async active-low reset
//   MemReq, MemAddr     : read request (held until acked) and word address
//   MemAck, MemRdata    : read completion (counted only while MemReq=1), data
//   InstrValid, Instr,
//   InstrPC, InstrReady : head of the queue towards the core (valid/ready)
//   Redirect, RedirectPC: flush the queue and restart fetch at RedirectPC
//   Halt                : block new requests (outstanding one completes)
//   Count               : queue occupancy
// -----------------------------------------------------------------------------
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int            AW       = 32,
  parameter  int            DEPTH    = 4,
  parameter  logic [AW-1:0] RESET_PC = '0,
  localparam int            CW       = $clog2(DEPTH + 1)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  output logic               MemReq,
  output logic [AW-1:0]      MemAddr,
  input  logic               MemAck,
  input  logic [INSTR_W-1:0] MemRdata,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [AW-1:0]      InstrPC,
  input  logic               InstrReady,
  input  logic               Redirect,
  input  logic [AW-1:0]      RedirectPC,
  input  logic               Halt,
  output logic [CW-1:0]      Count
);

  fetch_state_e           r_state;
  fetch_state_e           w_state_next;
  logic [AW-1:0]          r_pc;
  logic [AW-1:0]          w_pc_next;
  logic [AW-1:0]          r_stale_addr;  // address held on the bus while discarding
  logic [AW-1:0]          w_stale_next;
  logic                   w_ack;
  logic                   w_push;
  logic                   w_pop;
  logic [CW:0]            w_count_after;
  logic [INSTR_W+AW-1:0]  w_head;
  logic                   w_empty;
  logic                   w_full;

  // Request outputs decode straight from state, so an async reset drops
  // MemReq immediately.
  assign MemReq  = (r_state != ST_IDLE);
  assign MemAddr = (r_state == ST_DISCARD) ? r_stale_addr : r_pc;

  assign w_ack  = MemAck && MemReq;
  assign w_push = (r_state == ST_REQ) && w_ack && !Redirect;
  assign w_pop  = !w_empty && InstrReady && !Redirect;

  // Occupancy after this edge, used to decide whether to keep requesting.
  assign w_count_after = {1'b0, Count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W + AW)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .push      (w_push),
    .push_data ({MemRdata, MemAddr}),
    .pop       (w_pop),
    .flush     (Redirect),
    .head      (w_head),
    .count     (Count),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign InstrValid       = !w_empty;
  assign {Instr, InstrPC} = w_head;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_stale_addr <= w_stale_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_stale_next = r_stale_addr;

    if (w_push) begin
      w_pc_next = r_pc + AW'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (!Halt && !w_full) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (w_ack) begin
          w_state_next = (!Halt && (w_count_after < (CW+1)'(DEPTH))) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (w_ack) w_state_next = Halt ? ST_IDLE : ST_REQ;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Redirect overrides everything: the queue is flushed, so space is
    // guaranteed. A request still in flight must finish on the bus first,
    // with its data dropped.
    if (Redirect) begin
      w_pc_next = RedirectPC;
      if (MemReq && !w_ack) begin
        w_state_next = ST_DISCARD;
        w_stale_next = MemAddr;
      end else begin
        w_state_next = Halt ? ST_IDLE : ST_REQ;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
// Self-checking bench for instr_fetch_queue. A memory responder (zero-wait,
// fixed latency, or manual) serves requests; a scoreboard records every word
// expected to be enqueued and compares it against each pop seen at the core
// interface. Scenario tasks add their own direct checks.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LAT   = 3;

  typedef enum int {M_ZERO, M_LAT, M_MAN} mem_mode_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [AW-1:0]      pc;
  } entry_t;

  logic               Clk = 1'b0;
  logic               Rst_n = 1'b0;
  logic               MemReq;
  logic [AW-1:0]      MemAddr;
  logic               MemAck;
  logic [INSTR_W-1:0] MemRdata;
  logic               InstrValid;
  logic [INSTR_W-1:0] Instr;
  logic [AW-1:0]      InstrPC;
  logic               InstrReady = 1'b0;
  logic               Redirect = 1'b0;
  logic [AW-1:0]      RedirectPC = '0;
  logic               Halt = 1'b0;
  logic [CW-1:0]      Count;

  // Second instance starting at the top of the address space.
  logic               w2_req;
  logic [AW-1:0]      w2_addr;
  logic               w2_ivalid;
  logic [INSTR_W-1:0] w2_instr;
  logic [AW-1:0]      w2_ipc;
  logic [CW-1:0]      w2_count;

  mem_mode_e mem_mode = M_MAN;
  logic      lat_ack  = 1'b0;
  logic      man_ack  = 1'b0;
  int        lat_cnt  = 0;

  entry_t sb[$];
  bit     stale   = 1'b0;
  int     n_acks  = 0;
  int     n_pops  = 0;
  int     n_cmp   = 0;
  int     n_err   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign MemAck   = (mem_mode == M_ZERO) ? MemReq :
                    (mem_mode == M_LAT)  ? lat_ack : man_ack;
  assign MemRdata = mem_word(MemAddr);

  instr_fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemRdata   (MemRdata),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrReady (InstrReady),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Halt       (Halt),
    .Count      (Count)
  );

  instr_fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .MemReq     (w2_req),
    .MemAddr    (w2_addr),
    .MemAck     (w2_req),
    .MemRdata   (mem_word(w2_addr)),
    .InstrValid (w2_ivalid),
    .Instr      (w2_instr),
    .InstrPC    (w2_ipc),
    .InstrReady (1'b1),
    .Redirect   (1'b0),
    .RedirectPC ('0),
    .Halt       (1'b0),
    .Count      (w2_count)
  );

  always #5 Clk = ~Clk;

  // Fixed-latency responder: ack in the LAT-th cycle of each request.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (!Rst_n || mem_mode != M_LAT) begin
        lat_ack = 1'b0;
        lat_cnt = 0;
      end else if (lat_ack) begin
        lat_ack = 1'b0;
        lat_cnt = MemReq ? 1 : 0;
      end else if (MemReq) begin
        lat_cnt++;
        if (lat_cnt >= LAT) lat_ack = 1'b1;
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Scoreboard: sampled mid-cycle, i.e. the values the next rising edge sees.
  always @(negedge Clk) begin
    entry_t e;
    if (!Rst_n) begin
      sb.delete();
      stale = 1'b0;
    end else if (Redirect) begin
      sb.delete();
      if (MemReq && MemAck) begin
        n_acks++;
        stale = 1'b0;
      end else if (MemReq) begin
        stale = 1'b1;
      end
    end else begin
      if (InstrValid && InstrReady) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_pop: got pc=%h instr=%h, expected no valid entry", InstrPC, Instr);
        end else begin
          e = sb.pop_front();
          n_pops++;
          if (Instr !== e.instr || InstrPC !== e.pc) begin
            n_err++;
            $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                     InstrPC, Instr, e.pc, e.instr);
          end
        end
      end
      if (MemReq && MemAck) begin
        n_acks++;
        if (stale) begin
          stale = 1'b0;
        end else begin
          e.instr = mem_word(MemAddr);
          e.pc    = MemAddr;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Holds reset for two edges, then releases it mid-cycle.
  task automatic apply_reset();
    Rst_n      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    Halt       = 1'b0;
    InstrReady = 1'b0;
    man_ack    = 1'b0;
    tick(2);
    n_acks = 0;
    n_pops = 0;
    Rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    Rst_n    = 1'b0;
    mem_mode = M_ZERO;
    tick(1);
    n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL rst_memreq: got %b expected 0", MemReq); end
    n_cmp++; if (MemAddr !== 32'h0) begin n_err++; $display("FAIL rst_memaddr: got %h expected 0", MemAddr); end
    n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL rst_ivalid: got %b expected 0", InstrValid); end
    n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h expected 0", Instr); end
    n_cmp++; if (InstrPC !== 32'h0) begin n_err++; $display("FAIL rst_ipc: got %h expected 0", InstrPC); end
    n_cmp++; if (Count !== CW'(0)) begin n_err++; $display("FAIL rst_count: got %0d expected 0", Count); end
    n_cmp++; if (w2_addr !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_wrap_addr: got %h expected ffffffff", w2_addr); end
  endtask

  task automatic test_stream();
    mem_mode = M_ZERO;
    apply_reset();
    InstrReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n_cmp++;
      if (MemReq !== 1'b1 || MemAddr !== AW'(k)) begin
        n_err++;
        $display("FAIL stream_addr%0d: got req=%b addr=%h expected req=1 addr=%h", k, MemReq, MemAddr, AW'(k));
      end
      if (k == 0) begin
        n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid: got %b expected 0", InstrValid); end
      end
      if (k == 1) begin
        n_cmp++;
        if (InstrValid !== 1'b1 || Instr !== mem_word(32'h0) || InstrPC !== 32'h0) begin
          n_err++;
          $display("FAIL stream_first_head: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=0",
                   InstrValid, Instr, InstrPC, mem_word(32'h0));
        end
      end
    end
    n_cmp++; if (Count !== CW'(1)) begin n_err++; $display("FAIL stream_count: got %0d expected 1", Count); end
  endtask

  task automatic test_full();
    mem_mode = M_ZERO;
    apply_reset();
    tick(6);
    n_cmp++; if (Count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_count: got %0d expected %0d", Count, DEPTH); end
    n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL full_memreq: got %b expected 0", MemReq); end
    n_cmp++; if (n_acks != 4) begin n_err++; $display("FAIL full_nreq: got %0d expected 4", n_acks); end
    n_cmp++; if (InstrPC !== 32'h0) begin n_err++; $display("FAIL full_head_pc: got %h expected 0", InstrPC); end
    InstrReady = 1'b1;
    tick(1);
    InstrReady = 1'b0;
    n_cmp++; if (Count !== CW'(3)) begin n_err++; $display("FAIL full_pop_count: got %0d expected 3", Count); end
    n_cmp++; if (InstrPC !== 32'h1) begin n_err++; $display("FAIL full_pop_head: got %h expected 1", InstrPC); end
    n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL full_pop_req: got %b expected 0", MemReq); end
    tick(1);
    n_cmp++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h4) begin
      n_err++;
      $display("FAIL full_refill: got req=%b addr=%h expected req=1 addr=4", MemReq, MemAddr);
    end
    tick(1);
    n_cmp++; if (Count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_refill_count: got %0d expected %0d", Count, DEPTH); end
  endtask

  task automatic test_redirect_discard();
    bit found;
    bit saw_stale;
    mem_mode = M_LAT;
    apply_reset();
    InstrReady = 1'b1;
    found = 1'b0;
    saw_stale = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (MemReq === 1'b1 && MemAddr === 32'h2) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL disc_wait_req2: got timeout expected request for 2"); end
    Redirect   = 1'b1;
    RedirectPC = 32'h20;
    tick(1);
    Redirect = 1'b0;
    n_cmp++; if (dut.r_state !== ST_DISCARD) begin n_err++; $display("FAIL disc_state: got %0d expected %0d", dut.r_state, ST_DISCARD); end
    n_cmp++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h2) begin
      n_err++;
      $display("FAIL disc_hold: got req=%b addr=%h expected req=1 addr=2", MemReq, MemAddr);
    end
    n_cmp++; if (Count !== CW'(0)) begin n_err++; $display("FAIL disc_flush: got %0d expected 0", Count); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (InstrValid === 1'b1 && InstrPC === 32'h2) saw_stale = 1'b1;
      if (MemReq === 1'b1 && MemAddr === 32'h20) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL disc_new_addr: got timeout expected request for 20"); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (InstrValid === 1'b1 && InstrPC === 32'h2) saw_stale = 1'b1;
      if (InstrValid === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || InstrPC !== 32'h20 || Instr !== mem_word(32'h20)) begin
      n_err++;
      $display("FAIL disc_first_pc: got v=%b pc=%h instr=%h expected v=1 pc=20 instr=%h",
               found, InstrPC, Instr, mem_word(32'h20));
    end
    n_cmp++; if (saw_stale) begin n_err++; $display("FAIL disc_stale_seen: got stale pc 2 expected none"); end
  endtask

  task automatic test_redirect_ack_pop();
    mem_mode = M_MAN;
    apply_reset();
    tick(1);
    n_cmp++; if (MemReq !== 1'b1) begin n_err++; $display("FAIL rap_req0: got %b expected 1", MemReq); end
    man_ack = 1'b1;
    tick(2);
    n_cmp++;
    if (Count !== CW'(2) || MemAddr !== 32'h2) begin
      n_err++;
      $display("FAIL rap_pre: got count=%0d addr=%h expected count=2 addr=2", Count, MemAddr);
    end
    InstrReady = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h40;
    tick(1);
    Redirect   = 1'b0;
    InstrReady = 1'b0;
    man_ack    = 1'b0;
    n_cmp++;
    if (Count !== CW'(0) || InstrValid !== 1'b0) begin
      n_err++;
      $display("FAIL rap_flush: got count=%0d v=%b expected count=0 v=0", Count, InstrValid);
    end
    n_cmp++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h40) begin
      n_err++;
      $display("FAIL rap_new_req: got req=%b addr=%h expected req=1 addr=40", MemReq, MemAddr);
    end
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    n_cmp++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h40 || Instr !== mem_word(32'h40) || Count !== CW'(1)) begin
      n_err++;
      $display("FAIL rap_first: got v=%b pc=%h instr=%h count=%0d expected v=1 pc=40 instr=%h count=1",
               InstrValid, InstrPC, Instr, Count, mem_word(32'h40));
    end
  endtask

  task automatic test_halt();
    bit found;
    mem_mode = M_LAT;
    apply_reset();
    InstrReady = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (MemReq === 1'b1 && MemAddr === 32'h1) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL halt_wait_req1: got timeout expected request for 1"); end
    Halt = 1'b1;
    tick(10);
    n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL halt_memreq: got %b expected 0", MemReq); end
    n_cmp++; if (Count !== CW'(0) || InstrValid !== 1'b0) begin n_err++; $display("FAIL halt_drain: got count=%0d v=%b expected 0 0", Count, InstrValid); end
    n_cmp++; if (n_acks != 2) begin n_err++; $display("FAIL halt_nacks: got %0d expected 2", n_acks); end
    n_cmp++; if (n_pops != 2) begin n_err++; $display("FAIL halt_npops: got %0d expected 2", n_pops); end
    Halt = 1'b0;
    tick(1);
    n_cmp++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h2) begin
      n_err++;
      $display("FAIL halt_resume: got req=%b addr=%h expected req=1 addr=2", MemReq, MemAddr);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    tick(1);
    n_cmp++;
    if (w2_req !== 1'b1 || w2_addr !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_first: got req=%b addr=%h expected req=1 addr=ffffffff", w2_req, w2_addr);
    end
    tick(1);
    n_cmp++; if (w2_addr !== 32'h0) begin n_err++; $display("FAIL wrap_second: got %h expected 0", w2_addr); end
    n_cmp++;
    if (w2_ivalid !== 1'b1 || w2_ipc !== 32'hFFFF_FFFF || w2_instr !== mem_word(32'hFFFF_FFFF)) begin
      n_err++;
      $display("FAIL wrap_head: got v=%b pc=%h instr=%h expected v=1 pc=ffffffff instr=%h",
               w2_ivalid, w2_ipc, w2_instr, mem_word(32'hFFFF_FFFF));
    end
  endtask

  task automatic test_reset_mid();
    mem_mode = M_MAN;
    apply_reset();
    tick(1);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    tick(1);
    n_cmp++;
    if (Count !== CW'(1) || MemReq !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre: got count=%0d req=%b expected count=1 req=1", Count, MemReq);
    end
    Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (MemReq !== 1'b0 || InstrValid !== 1'b0 || Count !== CW'(0) || Instr !== 32'h0) begin
      n_err++;
      $display("FAIL rmid_async: got req=%b v=%b count=%0d instr=%h expected all 0",
               MemReq, InstrValid, Count, Instr);
    end
    tick(2);
    Rst_n   = 1'b1;
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    n_cmp++;
    if (Count !== CW'(0) || InstrValid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_late_ack: got count=%0d v=%b expected count=0 v=0", Count, InstrValid);
    end
    n_cmp++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0) begin
      n_err++;
      $display("FAIL rmid_restart: got req=%b addr=%h expected req=1 addr=0", MemReq, MemAddr);
    end
    tick(1);
    n_cmp++; if (InstrValid !== 1'b0) begin n_err++; $display("FAIL rmid_no_push: got %b expected 0", InstrValid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_discard();
    test_redirect_ack_pop();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
